// File: rtl/reg_file.sv
// 16 x DATA_W register file with one write port and two registered read
// ports. Synchronous active-low reset clears storage and both outputs.
// A read that hits the address being written in the same edge returns the
// incoming write data, so callers never see stale data on a same-cycle hit.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              WR,
  input  logic              RD,
  input  logic [DATA_W-1:0] Ip1,
  input  logic [ADDR_W-1:0] sel_i1,
  input  logic [ADDR_W-1:0] sel_o1,
  input  logic [ADDR_W-1:0] sel_o2,
  output logic [DATA_W-1:0] Op1,
  output logic [DATA_W-1:0] Op2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;
  logic              rd_en;

  assign wr_en = EN & WR;
  assign rd_en = EN & RD;

  // Storage update: clear everything on reset, otherwise take the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[sel_i1] <= Ip1;
    end
  end

  // Registered read ports with write-first bypass; hold when not reading.
  always_ff @(posedge clk) begin
    if (!rst) begin
      Op1 <= '0;
      Op2 <= '0;
    end else if (rd_en) begin
      Op1 <= (wr_en && (sel_o1 == sel_i1)) ? Ip1 : regs[sel_o1];
      Op2 <= (wr_en && (sel_o2 == sel_i1)) ? Ip1 : regs[sel_o2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: linear sequence of steps with
// hand-computed expected values, checked by immediate assertions.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        EN;
  logic        WR;
  logic        RD;
  logic [31:0] Ip1;
  logic [3:0]  sel_i1;
  logic [3:0]  sel_o1;
  logic [3:0]  sel_o2;
  logic [31:0] Op1;
  logic [31:0] Op2;

  int checks;
  int errors;

  reg_file #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .EN     (EN),
    .WR     (WR),
    .RD     (RD),
    .Ip1    (Ip1),
    .sel_i1 (sel_i1),
    .sel_o1 (sel_o1),
    .sel_o2 (sel_o2),
    .Op1    (Op1),
    .Op2    (Op2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    EN     = 1'b0;
    WR     = 1'b0;
    RD     = 1'b0;
    Ip1    = '0;
    sel_i1 = '0;
    sel_o1 = '0;
    sel_o2 = '0;

    // Reset held for 5 edges
    repeat (5) tick();
    check("reset_op1", Op1, 32'h0000_0000);
    check("reset_op2", Op2, 32'h0000_0000);

    // First read after reset
    rst = 1'b1; EN = 1'b1; RD = 1'b1; sel_o1 = 4'd0; sel_o2 = 4'd15;
    tick();
    check("post_reset_rd_op1", Op1, 32'h0000_0000);
    check("post_reset_rd_op2", Op2, 32'h0000_0000);

    // Two writes with RD=0: outputs hold
    RD = 1'b0; WR = 1'b1; sel_i1 = 4'd0; Ip1 = 32'hABCD_EFAB;
    tick();
    sel_i1 = 4'd1; Ip1 = 32'h0123_4567;
    tick();
    check("hold_during_wr_op1", Op1, 32'h0000_0000);

    // Read back both
    WR = 1'b0; RD = 1'b1; sel_o1 = 4'd0; sel_o2 = 4'd1;
    tick();
    check("rd_reg0", Op1, 32'hABCD_EFAB);
    check("rd_reg1", Op2, 32'h0123_4567);

    // EN=0: write blocked and outputs hold even with RD=1 at another address
    EN = 1'b0; WR = 1'b1; Ip1 = 32'hDEAD_BEEF; sel_i1 = 4'd0; sel_o1 = 4'd1; sel_o2 = 4'd0;
    tick();
    check("en0_hold_op1", Op1, 32'hABCD_EFAB);
    check("en0_hold_op2", Op2, 32'h0123_4567);
    EN = 1'b1; WR = 1'b0; RD = 1'b1; sel_o1 = 4'd0;
    tick();
    check("en0_wr_blocked", Op1, 32'hABCD_EFAB);

    // Write-first bypass on both ports
    WR = 1'b1; RD = 1'b1; sel_i1 = 4'd5; sel_o1 = 4'd5; sel_o2 = 4'd5; Ip1 = 32'h5A5A_5A5A;
    tick();
    check("bypass_op1", Op1, 32'h5A5A_5A5A);
    check("bypass_op2", Op2, 32'h5A5A_5A5A);

    // RD=0: hold across changing inputs
    WR = 1'b0; RD = 1'b0; sel_o1 = 4'd0; sel_o2 = 4'd1; Ip1 = 32'h0;
    repeat (2) tick();
    check("rd0_hold_op1", Op1, 32'h5A5A_5A5A);

    // Stored value of reg5 and reg0
    RD = 1'b1; sel_o1 = 4'd5; sel_o2 = 4'd0;
    tick();
    check("rd_reg5", Op1, 32'h5A5A_5A5A);
    check("rd_reg0_again", Op2, 32'hABCD_EFAB);

    // Simultaneous write/read at different addresses; bypass only on port 2
    WR = 1'b1; sel_i1 = 4'd3; Ip1 = 32'h3333_3333; sel_o1 = 4'd1; sel_o2 = 4'd3;
    tick();
    check("wr_rd_op1", Op1, 32'h0123_4567);
    check("wr_rd_op2_bypass", Op2, 32'h3333_3333);

    // Reset with a concurrent write: write discarded, outputs cleared
    rst = 1'b0; WR = 1'b1; RD = 1'b1; Ip1 = 32'h1111_1111; sel_i1 = 4'd2; sel_o1 = 4'd0; sel_o2 = 4'd1;
    tick();
    check("rst_edge_op1", Op1, 32'h0000_0000);
    check("rst_edge_op2", Op2, 32'h0000_0000);
    rst = 1'b1; WR = 1'b0;
    tick();
    check("rst_reg0", Op1, 32'h0000_0000);
    check("rst_reg1", Op2, 32'h0000_0000);
    sel_o1 = 4'd2; sel_o2 = 4'd5;
    tick();
    check("rst_reg2_wr_discarded", Op1, 32'h0000_0000);
    check("rst_reg5", Op2, 32'h0000_0000);

    // Top address, all ones
    WR = 1'b1; RD = 1'b0; sel_i1 = 4'd15; Ip1 = 32'hFFFF_FFFF;
    tick();
    WR = 1'b0; RD = 1'b1; sel_o1 = 4'd15; sel_o2 = 4'd15;
    tick();
    check("reg15_op1", Op1, 32'hFFFF_FFFF);
    check("reg15_op2", Op2, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
